uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame (5..9).
REQ-002 Parameter DIV_W, default 11, width of baud divisor.
REQ-003 Parameter OSR, default 16, oversample ticks per bit (even, >=8).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  asynchronous active-low reset.
REQ-007 Port br_div  in  DIV_W  tick divisor; tick period = br_div+1 clocks.
REQ-008 Port par_mode  in  2  0 none, 1 even, 2 odd, 3 treated as none.
REQ-009 Port two_stop  in  1  1 = TX sends two stop bits.
REQ-010 Port tx_start  in  1  one-cycle transmit request.
REQ-011 Port din  in  DATA_W  transmit data, sampled on accepted tx_start.
REQ-012 Port rx_i  in  1  asynchronous serial input, idle high.
REQ-013 Port tx_o  out  1  serial output, idle high.
REQ-014 Port tx_busy  out  1  high from acceptance until tx_done.
REQ-015 Port tx_done  out  1  one-cycle pulse at end of frame.
REQ-016 Port dout  out  DATA_W  last received word.
REQ-017 Port rx_done  out  1  one-cycle pulse, dout/flags valid.
REQ-018 Port parity_err  out  1  received parity mismatch.
REQ-019 Port frame_err  out  1  first stop bit sampled low.

Function
REQ-020 Baud generator free-running: counter 0..br_div, tick one cycle at br_div; br_div=0 gives tick every cycle; br_div change takes effect at next wrap.
REQ-021 TX states IDLE, START, DATA, PARITY, STOP1, STOP2; each state lasts OSR ticks.
REQ-022 tx_start accepted only in IDLE; din, par_mode, two_stop latched same edge; tx_start while busy ignored, no queueing.
REQ-023 tx_o drives start bit (0) from the cycle after acceptance; data LSB first.
REQ-024 PARITY skipped when mode none; even: parity bit = XOR of data; odd: inverted XOR.
REQ-025 STOP2 entered only if latched two_stop=1; tx_done pulses and tx_busy falls on the cycle the last stop period ends; tx_start same cycle as tx_done is accepted next cycle.
REQ-026 Frame length = (1+DATA_W+P+S)*OSR ticks, P in {0,1}, S in {1,2}; first bit may be short by <1 tick (free-running generator).
REQ-027 rx_i passes a 2-flop synchronizer before any use.
REQ-028 RX states IDLE, START, DATA, PARITY, STOP; IDLE leaves on synchronized low seen on a tick.
REQ-029 START re-samples at OSR/2 ticks; high -> false start, back to IDLE, no pulse.
REQ-030 Data, parity, stop sampled every OSR ticks after mid-start; RX uses live par_mode latched at start detect; RX checks one stop bit only.
REQ-031 At stop sample: dout, parity_err, frame_err update and rx_done pulses in the same cycle; frame_err does not suppress dout update.
REQ-032 Error flags hold until next rx_done; parity_err=0 when mode none.
REQ-033 After STOP, RX returns to IDLE and requires rx_i high before a new start detect (break does not retrigger).
REQ-034 TX and RX fully independent; simultaneous operation supported.

Reset
REQ-035 rst low asynchronously forces tx_o=1, tx_busy=0, tx_done=0, rx_done=0, dout=0, parity_err=0, frame_err=0, both FSMs IDLE, baud counter 0, synchronizer flops 1.
REQ-036 Reset mid-frame aborts both directions; no done pulse on release.

Structure
REQ-037 Package uart_pkg holds par_mode enum, TX/RX state enums, default OSR.
REQ-038 Baud tick generator is sub-module uart_baud_gen; TX/RX FSMs stay in uart_ctrl.

Verification (clk 10 ns, br_div=3, OSR=16, DATA_W=8; bit = 64 clocks)
REQ-039 Loopback rx_i=tx_o, mode none, din=8'hA5 -> tx_done ~640 clocks after start, rx_done with dout=8'hA5, no errors.
REQ-040 Even parity din=8'h07 -> line parity bit 1, no error; bench inverts parity bit -> parity_err=1, dout=8'h07.
REQ-041 Bench drives stop bit low for 8'h3C -> rx_done pulses, dout=8'h3C, frame_err=1; next clean frame clears it.
REQ-042 rx_i low for 4 ticks then high -> no rx_done, RX back in IDLE.
REQ-043 two_stop=1, odd parity -> frame 12 bits (768 clocks); tx_start during busy ignored.
REQ-044 rst low at DATA bit 3 -> tx_o=1, tx_busy=0 immediately; no tx_done/rx_done after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART: parity modes, TX/RX state encodings, default oversample ratio.
package uart_pkg;

    localparam int DEFAULT_OSR = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } par_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Reserved mode 3 behaves as no parity.
    function automatic logic par_enabled(input par_mode_e m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-cycle tick every br_div+1 clocks.
// The divisor is captured at each wrap so a change never produces a runt period.
module uart_baud_gen #(
    parameter int DIV_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] br_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    assign tick = (cnt == div_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (tick) begin
            cnt   <= '0;
            div_q <= br_div;
        end else begin
            cnt   <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Full-duplex UART: oversampled TX and RX state machines sharing one baud tick.
// TX accepts a new word only when idle; RX has no backpressure (dout overwritten per frame).
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 11,
    parameter int OSR    = DEFAULT_OSR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  br_div,
    input  logic [1:0]        par_mode,
    input  logic              two_stop,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] din,
    input  logic              rx_i,
    output logic              tx_o,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [DATA_W-1:0] dout,
    output logic              rx_done,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int CW = $clog2(OSR);
    localparam int IW = $clog2(DATA_W);

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .br_div (br_div),
        .tick   (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_e         tx_state;
    logic [CW-1:0]     tx_cnt;
    logic [IW-1:0]     tx_idx;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_par;
    logic              tx_pen;
    logic              tx_two;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_o     <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
            tx_two   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state <= TX_START;
                        tx_o     <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_cnt   <= '0;
                        tx_sh    <= din;
                        tx_pen   <= par_enabled(par_mode_e'(par_mode));
                        tx_par   <= (^din) ^ (par_mode_e'(par_mode) == PAR_ODD);
                        tx_two   <= two_stop;
                    end
                end
                default: begin
                    if (tick) begin
                        if (tx_cnt != CW'(OSR - 1)) begin
                            tx_cnt <= tx_cnt + CW'(1);
                        end else begin
                            tx_cnt <= '0;
                            case (tx_state)
                                TX_START: begin
                                    tx_state <= TX_DATA;
                                    tx_idx   <= '0;
                                    tx_o     <= tx_sh[0];
                                    tx_sh    <= tx_sh >> 1;
                                end
                                TX_DATA: begin
                                    if (tx_idx == IW'(DATA_W - 1)) begin
                                        tx_state <= tx_pen ? TX_PARITY : TX_STOP1;
                                        tx_o     <= tx_pen ? tx_par : 1'b1;
                                    end else begin
                                        tx_idx <= tx_idx + IW'(1);
                                        tx_o   <= tx_sh[0];
                                        tx_sh  <= tx_sh >> 1;
                                    end
                                end
                                TX_PARITY: begin
                                    tx_state <= TX_STOP1;
                                    tx_o     <= 1'b1;
                                end
                                TX_STOP1: begin
                                    if (tx_two) begin
                                        tx_state <= TX_STOP2;
                                    end else begin
                                        tx_state <= TX_IDLE;
                                        tx_busy  <= 1'b0;
                                        tx_done  <= 1'b1;
                                    end
                                end
                                default: begin
                                    tx_state <= TX_IDLE;
                                    tx_o     <= 1'b1;
                                    tx_busy  <= 1'b0;
                                    tx_done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [1:0]        rx_sync;
    logic              rx_s;
    rx_state_e         rx_state;
    logic [CW-1:0]     rx_cnt;
    logic [IW-1:0]     rx_idx;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_pbit;
    par_mode_e         rx_mode;
    logic              rx_armed;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx_i};
        end
    end

    // rx_armed blocks a held-low line (break) from re-triggering after a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_pbit    <= 1'b0;
            rx_mode    <= PAR_NONE;
            rx_armed   <= 1'b0;
            dout       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_done    <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s) begin
                        rx_armed <= 1'b1;
                    end
                    if (tick && rx_armed && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                        rx_mode  <= par_mode_e'(par_mode);
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_cnt == CW'(OSR / 2 - 1)) begin
                            rx_cnt   <= '0;
                            rx_idx   <= '0;
                            rx_state <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (rx_cnt != CW'(OSR - 1)) begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end else begin
                            rx_cnt <= '0;
                            case (rx_state)
                                RX_DATA: begin
                                    rx_sh <= {rx_s, rx_sh[DATA_W-1:1]};
                                    if (rx_idx == IW'(DATA_W - 1)) begin
                                        rx_state <= par_enabled(rx_mode) ? RX_PARITY : RX_STOP;
                                    end else begin
                                        rx_idx <= rx_idx + IW'(1);
                                    end
                                end
                                RX_PARITY: begin
                                    rx_pbit  <= rx_s;
                                    rx_state <= RX_STOP;
                                end
                                default: begin
                                    dout       <= rx_sh;
                                    frame_err  <= !rx_s;
                                    parity_err <= par_enabled(rx_mode) &&
                                                  (((^rx_sh) ^ rx_pbit) != (rx_mode == PAR_ODD));
                                    rx_done    <= 1'b1;
                                    rx_armed   <= 1'b0;
                                    rx_state   <= RX_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Randomized directed bench for uart_ctrl: line-level frame model, loopback and bench-driven RX frames.
module tb_uart_ctrl;

    localparam int BITCLK = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] br_div = 11'd3;
    logic [1:0]  par_mode = 2'd0;
    logic        two_stop = 1'b0;
    logic        tx_start = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        rx_i;
    logic        tx_o, tx_busy, tx_done, rx_done, parity_err, frame_err;
    logic [7:0]  dout;

    logic loop = 1'b1;
    logic rx_drv = 1'b1;
    assign rx_i = loop ? tx_o : rx_drv;

    int vectors = 0;
    int miscompares = 0;
    int tx_pulses = 0;
    int rx_pulses = 0;
    bit fb [0:12];

    uart_ctrl #(.DATA_W(8), .DIV_W(11), .OSR(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_div     (br_div),
        .par_mode   (par_mode),
        .two_stop   (two_stop),
        .tx_start   (tx_start),
        .din        (din),
        .rx_i       (rx_i),
        .tx_o       (tx_o),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .dout       (dout),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_done) tx_pulses <= tx_pulses + 1;
        if (rx_done) rx_pulses <= rx_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line image of one frame: start, data LSB first, optional parity, stop bit(s).
    task automatic make_frame(input logic [7:0] d, input int pm, input bit ts, output int nb);
        nb = 0;
        fb[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            fb[nb] = d[i]; nb++;
        end
        if (pm == 1) begin
            fb[nb] = ($countones(d) % 2) == 1; nb++;
        end else if (pm == 2) begin
            fb[nb] = ($countones(d) % 2) == 0; nb++;
        end
        fb[nb] = 1'b1; nb++;
        if (ts) begin
            fb[nb] = 1'b1; nb++;
        end
    endtask

    task automatic tx_frame(input string tag, input logic [7:0] d, input int pm, input bit ts, input bit poke);
        int nb, done_at, t0, r0;
        make_frame(d, pm, ts, nb);
        t0 = tx_pulses;
        r0 = rx_pulses;
        din = d; par_mode = pm[1:0]; two_stop = ts; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        done_at = -1;
        for (int j = 1; j <= nb * BITCLK + 40; j++) begin
            if (poke) begin
                tx_start = (j == 200);
                if (j == 200) din = ~d;
            end
            if ((j % BITCLK) == BITCLK / 2 && (j / BITCLK) < nb)
                check($sformatf("%s_bit%0d", tag, j / BITCLK), 32'(tx_o), 32'(fb[j / BITCLK]));
            if (j == 100) check($sformatf("%s_busy", tag), 32'(tx_busy), 32'd1);
            if (tx_done) begin
                done_at = j;
                break;
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        check($sformatf("%s_len", tag),
              (done_at >= nb * BITCLK - 2 && done_at <= nb * BITCLK + 1) ? nb * BITCLK : done_at,
              nb * BITCLK);
        repeat (4) @(negedge clk);
        check($sformatf("%s_txdone_cnt", tag), tx_pulses - t0, 32'd1);
        if (loop) begin
            check($sformatf("%s_rxdone_cnt", tag), rx_pulses - r0, 32'd1);
            check($sformatf("%s_dout", tag), 32'(dout), 32'(d));
            check($sformatf("%s_perr", tag), 32'(parity_err), 32'd0);
            check($sformatf("%s_ferr", tag), 32'(frame_err), 32'd0);
        end
        if (poke) begin
            repeat (100) @(negedge clk);
            check($sformatf("%s_no_requeue", tag), 32'(tx_busy), 32'd0);
            check($sformatf("%s_txdone_once", tag), tx_pulses - t0, 32'd1);
        end
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] d, input int pm,
                            input bit flip_par, input bit stop_val, input int tail_low);
        int nb, r0;
        bit exp_pe;
        make_frame(d, pm, 1'b0, nb);
        exp_pe = flip_par && (pm == 1 || pm == 2);
        if (exp_pe) fb[9] = ~fb[9];
        fb[nb - 1] = stop_val;
        par_mode = pm[1:0];
        r0 = rx_pulses;
        for (int k = 0; k < nb; k++) begin
            rx_drv = fb[k];
            repeat (BITCLK) @(negedge clk);
        end
        if (tail_low > 0) begin
            rx_drv = 1'b0;
            repeat (tail_low * BITCLK) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * BITCLK) @(negedge clk);
        check($sformatf("%s_rxdone_cnt", tag), rx_pulses - r0, 32'd1);
        check($sformatf("%s_dout", tag), 32'(dout), 32'(d));
        check($sformatf("%s_perr", tag), 32'(parity_err), 32'(exp_pe));
        check($sformatf("%s_ferr", tag), 32'(frame_err), 32'(!stop_val));
    endtask

    initial begin
        int t0, r0;
        repeat (3) @(negedge clk);
        check("rst_tx_o", 32'(tx_o), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        tx_frame("loop_a5", 8'hA5, 0, 1'b0, 1'b0);
        tx_frame("even_07", 8'h07, 1, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++)
            tx_frame($sformatf("rnd%0d", n), 8'($urandom), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0);
        tx_frame("odd_two_stop", 8'($urandom), 2, 1'b1, 1'b1);

        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        rx_frame("par_flip", 8'h07, 1, 1'b1, 1'b1, 0);
        rx_frame("stop_low", 8'h3C, 0, 1'b0, 1'b0, 3);
        rx_frame("clean", 8'($urandom), 0, 1'b0, 1'b1, 0);

        r0 = rx_pulses;
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        check("false_start", rx_pulses - r0, 32'd0);
        rx_frame("after_false", 8'($urandom), 2, 1'b0, 1'b1, 0);

        loop = 1'b1;
        repeat (50) @(negedge clk);
        t0 = tx_pulses;
        r0 = rx_pulses;
        din = 8'hA5; par_mode = 2'd0; two_stop = 1'b0; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * BITCLK + BITCLK / 2 - 1) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_tx_o", 32'(tx_o), 32'd1);
        check("midrst_tx_busy", 32'(tx_busy), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (1500) @(negedge clk);
        check("midrst_no_txdone", tx_pulses - t0, 32'd0);
        check("midrst_no_rxdone", rx_pulses - r0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
